fx1_issue_sched: RTL

- Issue scheduler and pipeline controller for the even-pipe simple fixed-point (FX1) unit.
- Arbitrates round-robin between two issue requesters and sequences accepted ops through a 2-stage FX1 pipeline: halfword/word add, add-immediate and subtract-from.
- Presents results on a valid/ready writeback port with backpressure and flush.
- Sits between the issue/dispatch logic and the register-file writeback.

---
 rtl/fx1_issue_sched.sv | 313 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/fx1_issue_sched.sv
// -----------------------------------------------------------------------------
// fx1_issue_sched
//
// Issue scheduler and pipeline controller for the even-pipe simple fixed-point
// (FX1) unit. Two issue requesters are arbitrated round-robin. Accepted ops
// flow through a 2-stage pipeline (E1: operands, E2: result). Results leave on
// a valid/ready writeback port.
//
// Bit numbering on all ports is big-endian: bit 0 is the MSB. Internally the
// datapath uses descending [N-1:0] vectors. Assigning a [0:N-1] port to a
// [N-1:0] signal (or the reverse) maps MSB to MSB. Lane arithmetic is
// identical in every lane, so lane order is irrelevant to the result.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   reqX_valid/ready      requester X handshake (ready is combinational)
//   reqX_op/rt/ra/rb/imm  requester X opcode, destination, operands, immediate
//   flush                 kill every in-flight op this cycle
//   wb_valid/ready        writeback handshake
//   wb_rt/result/src      writeback destination, result, issuing requester
//   wb_illegal            op carried an undefined opcode (result forced to 0)
//   busy                  E1 or E2 holds a valid op
//
// Optional build macro: FX1_PERF_CNT_EN
//   Adds 32-bit wrapping counters for grants per requester, writeback stall
//   cycles and flushes that killed something. They appear on the outputs
//   perf_issue0, perf_issue1, perf_stall and perf_flush.
// -----------------------------------------------------------------------------
module fx1_issue_sched #(
    parameter int RT_W = 7,
    parameter int OP_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [0:OP_W-1]   req0_op,
    input  logic [0:RT_W-1]   req0_rt,
    input  logic [0:127]      req0_ra,
    input  logic [0:127]      req0_rb,
    input  logic [0:9]        req0_imm,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [0:OP_W-1]   req1_op,
    input  logic [0:RT_W-1]   req1_rt,
    input  logic [0:127]      req1_ra,
    input  logic [0:127]      req1_rb,
    input  logic [0:9]        req1_imm,

    input  logic              flush,

    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [0:RT_W-1]   wb_rt,
    output logic [0:127]      wb_result,
    output logic              wb_src,
    output logic              wb_illegal,

    output logic              busy
`ifdef FX1_PERF_CNT_EN
    ,
    output logic [0:31]       perf_issue0,
    output logic [0:31]       perf_issue1,
    output logic [0:31]       perf_stall,
    output logic [0:31]       perf_flush
`endif
);

    localparam logic [OP_W-1:0] OP_AH  = OP_W'(0);
    localparam logic [OP_W-1:0] OP_AHI = OP_W'(1);
    localparam logic [OP_W-1:0] OP_A   = OP_W'(2);
    localparam logic [OP_W-1:0] OP_AI  = OP_W'(3);
    localparam logic [OP_W-1:0] OP_SFH = OP_W'(4);
    localparam logic [OP_W-1:0] OP_SF  = OP_W'(5);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic              rr_q,        rr_d;
    logic              e1_valid_q,  e1_valid_d;
    logic [OP_W-1:0]   e1_op_q,     e1_op_d;
    logic [RT_W-1:0]   e1_rt_q,     e1_rt_d;
    logic [127:0]      e1_ra_q,     e1_ra_d;
    logic [127:0]      e1_rb_q,     e1_rb_d;
    logic [9:0]        e1_imm_q,    e1_imm_d;
    logic              e1_src_q,    e1_src_d;

    logic              e2_valid_q,  e2_valid_d;
    logic [127:0]      e2_result_q, e2_result_d;
    logic [RT_W-1:0]   e2_rt_q,     e2_rt_d;
    logic              e2_src_q,    e2_src_d;
    logic              e2_illegal_q, e2_illegal_d;

    // ------------------------------------------------------------------
    // Pipeline advance and arbitration
    // ------------------------------------------------------------------
    logic e2_can_load;
    logic e1_move;
    logic e1_can_accept;
    logic win0;
    logic grant;
    logic grant0;
    logic grant1;

    assign e2_can_load   = !e2_valid_q || wb_ready;
    assign e1_move       = e1_valid_q && e2_can_load;
    assign e1_can_accept = !e1_valid_q || e1_move;

    // Requester 0 wins when alone, or when both request and it is its turn.
    assign win0   = req0_valid && (!req1_valid || (rr_q == 1'b0));
    // rst_n gates the grant so ready reads 0 while reset is asserted.
    assign grant  = rst_n && !flush && e1_can_accept && (req0_valid || req1_valid);
    assign grant0 = grant && win0;
    assign grant1 = grant && !win0;

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    // Selected request, converted to internal descending order.
    logic [OP_W-1:0] sel_op;
    logic [RT_W-1:0] sel_rt;
    logic [127:0]    sel_ra;
    logic [127:0]    sel_rb;
    logic [9:0]      sel_imm;

    always_comb begin
        if (win0) begin
            sel_op  = req0_op;
            sel_rt  = req0_rt;
            sel_ra  = req0_ra;
            sel_rb  = req0_rb;
            sel_imm = req0_imm;
        end else begin
            sel_op  = req1_op;
            sel_rt  = req1_rt;
            sel_ra  = req1_ra;
            sel_rb  = req1_rb;
            sel_imm = req1_imm;
        end
    end

    // ------------------------------------------------------------------
    // E1 execute: lane-wise arithmetic, no carries across lanes
    // ------------------------------------------------------------------
    logic [127:0] ex_result;
    logic         ex_illegal;
    logic [15:0]  imm16;
    logic [31:0]  imm32;

    assign imm16 = {{6{e1_imm_q[9]}},  e1_imm_q};
    assign imm32 = {{22{e1_imm_q[9]}}, e1_imm_q};

    always_comb begin
        ex_result  = '0;
        ex_illegal = 1'b0;
        case (e1_op_q)
            OP_AH: begin
                for (int i = 0; i < 8; i++)
                    ex_result[i*16 +: 16] = e1_ra_q[i*16 +: 16] + e1_rb_q[i*16 +: 16];
            end
            OP_AHI: begin
                for (int i = 0; i < 8; i++)
                    ex_result[i*16 +: 16] = e1_ra_q[i*16 +: 16] + imm16;
            end
            OP_A: begin
                for (int i = 0; i < 4; i++)
                    ex_result[i*32 +: 32] = e1_ra_q[i*32 +: 32] + e1_rb_q[i*32 +: 32];
            end
            OP_AI: begin
                for (int i = 0; i < 4; i++)
                    ex_result[i*32 +: 32] = e1_ra_q[i*32 +: 32] + imm32;
            end
            OP_SFH: begin
                for (int i = 0; i < 8; i++)
                    ex_result[i*16 +: 16] = e1_rb_q[i*16 +: 16] - e1_ra_q[i*16 +: 16];
            end
            OP_SF: begin
                for (int i = 0; i < 4; i++)
                    ex_result[i*32 +: 32] = e1_rb_q[i*32 +: 32] - e1_ra_q[i*32 +: 32];
            end
            default: begin
                ex_result  = '0;
                ex_illegal = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state
    // ------------------------------------------------------------------
    always_comb begin
        rr_d         = rr_q;
        e1_valid_d   = e1_valid_q;
        e1_op_d      = e1_op_q;
        e1_rt_d      = e1_rt_q;
        e1_ra_d      = e1_ra_q;
        e1_rb_d      = e1_rb_q;
        e1_imm_d     = e1_imm_q;
        e1_src_d     = e1_src_q;
        e2_valid_d   = e2_valid_q;
        e2_result_d  = e2_result_q;
        e2_rt_d      = e2_rt_q;
        e2_src_d     = e2_src_q;
        e2_illegal_d = e2_illegal_q;

        if (flush) begin
            // Flush wins over a simultaneous writeback handshake; data
            // registers keep stale contents behind cleared valids.
            e1_valid_d = 1'b0;
            e2_valid_d = 1'b0;
        end else begin
            if (e2_can_load) begin
                e2_valid_d = e1_valid_q;
                if (e1_valid_q) begin
                    e2_result_d  = ex_result;
                    e2_rt_d      = e1_rt_q;
                    e2_src_d     = e1_src_q;
                    e2_illegal_d = ex_illegal;
                end
            end
            if (e1_can_accept) begin
                e1_valid_d = grant;
                if (grant) begin
                    e1_op_d  = sel_op;
                    e1_rt_d  = sel_rt;
                    e1_ra_d  = sel_ra;
                    e1_rb_d  = sel_rb;
                    e1_imm_d = sel_imm;
                    e1_src_d = !win0;
                    rr_d     = win0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_q         <= 1'b0;
            e1_valid_q   <= 1'b0;
            e1_op_q      <= '0;
            e1_rt_q      <= '0;
            e1_ra_q      <= '0;
            e1_rb_q      <= '0;
            e1_imm_q     <= '0;
            e1_src_q     <= 1'b0;
            e2_valid_q   <= 1'b0;
            e2_result_q  <= '0;
            e2_rt_q      <= '0;
            e2_src_q     <= 1'b0;
            e2_illegal_q <= 1'b0;
        end else begin
            rr_q         <= rr_d;
            e1_valid_q   <= e1_valid_d;
            e1_op_q      <= e1_op_d;
            e1_rt_q      <= e1_rt_d;
            e1_ra_q      <= e1_ra_d;
            e1_rb_q      <= e1_rb_d;
            e1_imm_q     <= e1_imm_d;
            e1_src_q     <= e1_src_d;
            e2_valid_q   <= e2_valid_d;
            e2_result_q  <= e2_result_d;
            e2_rt_q      <= e2_rt_d;
            e2_src_q     <= e2_src_d;
            e2_illegal_q <= e2_illegal_d;
        end
    end

    assign wb_valid   = e2_valid_q;
    assign wb_rt      = e2_rt_q;
    assign wb_result  = e2_result_q;
    assign wb_src     = e2_src_q;
    assign wb_illegal = e2_illegal_q;
    assign busy       = e1_valid_q || e2_valid_q;

`ifdef FX1_PERF_CNT_EN
    // ------------------------------------------------------------------
    // Performance counters (wrap at 2^32)
    // ------------------------------------------------------------------
    logic [31:0] issue0_cnt_q, issue0_cnt_d;
    logic [31:0] issue1_cnt_q, issue1_cnt_d;
    logic [31:0] stall_cnt_q,  stall_cnt_d;
    logic [31:0] flush_cnt_q,  flush_cnt_d;

    always_comb begin
        issue0_cnt_d = issue0_cnt_q + {31'd0, grant0};
        issue1_cnt_d = issue1_cnt_q + {31'd0, grant1};
        stall_cnt_d  = stall_cnt_q  + {31'd0, (e2_valid_q && !wb_ready)};
        flush_cnt_d  = flush_cnt_q  + {31'd0, (flush && (e1_valid_q || e2_valid_q))};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            issue0_cnt_q <= '0;
            issue1_cnt_q <= '0;
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
        end else begin
            issue0_cnt_q <= issue0_cnt_d;
            issue1_cnt_q <= issue1_cnt_d;
            stall_cnt_q  <= stall_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    assign perf_issue0 = issue0_cnt_q;
    assign perf_issue1 = issue1_cnt_q;
    assign perf_stall  = stall_cnt_q;
    assign perf_flush  = flush_cnt_q;
`endif

endmodule
